// File: rtl/vector_pkg.sv
// vector_pkg: shared types and display-list entry layout
// for the vector sequencer and its optional frame timer.
package vector_pkg;

  localparam int ENTRY_W  = 26;
  localparam int COORD_W  = 12;
  localparam int EOF_BIT  = 25;
  localparam int DRAW_BIT = 24;
  localparam int Y_MSB    = 23;
  localparam int Y_LSB    = 12;
  localparam int X_MSB    = 11;
  localparam int X_LSB    = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    JUMP,
    ISSUE,
    WAIT_READY,
    FRAME_END
  } seq_state_e;

  function automatic logic entry_eof(
    input logic [ENTRY_W-1:0] e
  );
    return e[EOF_BIT];
  endfunction

  function automatic logic entry_draw(
    input logic [ENTRY_W-1:0] e
  );
    return e[DRAW_BIT];
  endfunction

  function automatic logic [COORD_W-1:0] entry_x(
    input logic [ENTRY_W-1:0] e
  );
    return e[X_MSB:X_LSB];
  endfunction

  function automatic logic [COORD_W-1:0] entry_y(
    input logic [ENTRY_W-1:0] e
  );
    return e[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: saturating cycle count from frame start;
// done once MIN_FRAME_CYC-1 cycles have elapsed.
module frame_timer #(
  parameter int MIN_FRAME_CYC = 400000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic done
);

  localparam int LIMIT =
    (MIN_FRAME_CYC > 1) ? MIN_FRAME_CYC - 1 : 0;
  localparam int CNT_W = $clog2(LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  // restart on frame start, otherwise count up and hold at limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (count != LIMIT_C) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LIMIT_C);

endmodule

// File: rtl/vector_sequencer.sv
// vector_sequencer: walks a double-buffered display list and
// feeds jump/draw points to a line engine. MIN_FRAME_TIMER_EN
// adds a minimum frame period (frame_timer sub-module).
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int MIN_FRAME_CYC = 400000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                buf_swap,
  output logic [ADDR_W:0]     mem_addr,
  output logic                mem_rd,
  input  logic [ENTRY_W-1:0]  mem_data,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic                draw,
  output logic                jump,
  input  logic                line_ready,
  output logic                blank,
  output logic                bank,
  output logic                busy,
  output logic                frame_done
);

  if (MIN_FRAME_CYC < 1) begin : g_cfg_chk
    $error("MIN_FRAME_CYC must be at least 1");
  end

  seq_state_e        state;
  logic [ADDR_W-1:0] addr;
  logic              swap_pend;
  logic              frame_ok;

`ifdef MIN_FRAME_TIMER_EN
  logic frame_start;

  assign frame_start = enable &&
    ((state == IDLE) ||
     ((state == FRAME_END) && frame_ok));

  frame_timer #(
    .MIN_FRAME_CYC (MIN_FRAME_CYC)
  ) u_frame_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (frame_start),
    .done    (frame_ok)
  );
`else
  assign frame_ok = 1'b1;
`endif

  assign mem_addr = {bank, addr};

  // sequencer FSM with registered strobes and point outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      bank       <= 1'b0;
      swap_pend  <= 1'b0;
      x          <= '0;
      y          <= '0;
      draw       <= 1'b0;
      jump       <= 1'b0;
      mem_rd     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      blank      <= 1'b1;
    end else begin
      mem_rd     <= 1'b0;
      draw       <= 1'b0;
      jump       <= 1'b0;
      frame_done <= 1'b0;
      if (buf_swap) begin
        swap_pend <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (enable) begin
            addr   <= '0;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (entry_eof(mem_data)) begin
            state <= FRAME_END;
          end else begin
            x <= entry_x(mem_data);
            y <= entry_y(mem_data);
            if (entry_draw(mem_data)) begin
              blank <= 1'b0;
              state <= ISSUE;
            end else begin
              blank <= 1'b1;
              jump  <= 1'b1;
              state <= JUMP;
            end
          end
        end
        JUMP: begin
          state <= ISSUE;
        end
        ISSUE: begin
          if (line_ready) begin
            draw  <= 1'b1;
            state <= WAIT_READY;
          end
        end
        WAIT_READY: begin
          // draw is still high in the first cycle: ignore ready
          if (!draw && line_ready) begin
            if (&addr) begin
              state <= FRAME_END;
            end else begin
              addr   <= addr + 1'b1;
              mem_rd <= 1'b1;
              state  <= FETCH;
            end
          end
        end
        FRAME_END: begin
          if (frame_ok) begin
            frame_done <= 1'b1;
            bank       <= bank ^ (swap_pend | buf_swap);
            swap_pend  <= 1'b0;
            addr       <= '0;
            blank      <= 1'b1;
            if (enable) begin
              mem_rd <= 1'b1;
              state  <= FETCH;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving display-list word address width per bank.
REQ-002 SHALL have parameter MIN_FRAME_CYC, default 400000, giving minimum clk cycles from frame start to next frame start.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  permits frames to start.
REQ-006 SHALL have port buf_swap  input  1  one-cycle request to toggle the display bank.
REQ-007 SHALL have port mem_addr  output  ADDR_W+1  display-list address; MSB is the bank.
REQ-008 SHALL have port mem_rd  output  1  read strobe.
REQ-009 SHALL have port mem_data  input  26  entry: [25] eof, [24] draw(1)/jump(0), [23:12] y, [11:0] x; valid 1 cycle after mem_rd.
REQ-010 SHALL have ports x, y  output  12 each  target point to the line engine.
REQ-011 SHALL have ports draw, jump  output  1 each  one-cycle strobes to the line engine.
REQ-012 SHALL have port line_ready  input  1  line engine ready for the next point.
REQ-013 SHALL have port blank  output  1  beam off during jump moves.
REQ-014 SHALL have ports bank, busy, frame_done  output  1 each  displayed bank; frame in progress; one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement states IDLE, FETCH, WAIT_DATA, JUMP, ISSUE, WAIT_READY, FRAME_END.
REQ-016 IDLE: when enable=1, SHALL clear the word address and go to FETCH; busy=1 in every state except IDLE.
REQ-017 FETCH: SHALL assert mem_rd for one cycle at {bank, addr}, then enter WAIT_DATA; the entry is captured the following cycle.
REQ-018 Captured eof=1 SHALL go to FRAME_END; an eof entry is a terminator and SHALL NOT be drawn.
REQ-019 Captured jump entry SHALL latch x/y, pulse jump one cycle with blank=1, then enter ISSUE with blank held 1.
REQ-020 Captured draw entry SHALL latch x/y, set blank=0, and enter ISSUE.
REQ-021 ISSUE: SHALL wait for line_ready=1, then pulse draw one cycle; x/y SHALL remain stable from the latch until the strobe.
REQ-022 WAIT_READY: SHALL ignore line_ready in the cycle after the strobe, then wait for line_ready=1, increment addr and return to FETCH.
REQ-023 If addr reaches 2^ADDR_W-1 without eof, SHALL process that entry, then treat it as end of frame without wrap-around.
REQ-024 FRAME_END: SHALL pulse frame_done once, apply any pending swap to bank, then go to FETCH at addr 0 if enable=1, else IDLE.
REQ-025 buf_swap SHALL be latched as pending in any state and cleared when applied; multiple requests within one frame SHALL toggle bank once.
REQ-026 enable deasserted mid-frame SHALL NOT abort; the current frame SHALL complete.
REQ-027 A draw strobe and a jump strobe SHALL NOT both be high in one cycle.

Reset
REQ-028 reset_n=0 SHALL force, asynchronously and mid-operation: state IDLE, addr 0, bank 0, swap pending 0, timer 0, x=y=0, draw=jump=mem_rd=frame_done=busy=0, blank=1.

Configuration
REQ-029 With MIN_FRAME_TIMER_EN defined, a saturating cycle counter starting at frame start SHALL hold FRAME_END (frame_done not yet pulsed) until count >= MIN_FRAME_CYC-1.
REQ-030 Without MIN_FRAME_TIMER_EN, SHALL include no counter; FRAME_END SHALL last one cycle.

Structure
REQ-031 SHALL place the state enum, entry field bit positions and the 26-bit entry width in shared package vector_pkg.
REQ-032 SHALL use sub-module frame_timer (counter, compare, done flag), instantiated only under MIN_FRAME_TIMER_EN.

Verification
REQ-033 List {draw(100,200), eof}, line_ready=1 -> one draw pulse with x=100,y=200,blank=0, then frame_done.
REQ-034 List {jump(10,20), draw(30,40), eof} -> jump pulse blank=1, draw(10,20) blank=1, draw(30,40) blank=0, in that order.
REQ-035 line_ready held low 50 cycles before the 2nd point -> draw pulse only after it rises; x/y stable throughout.
REQ-036 buf_swap pulsed twice mid-frame -> bank toggles 0->1 only at frame_done; the next frame's mem_addr MSB=1.
REQ-037 reset_n low during WAIT_READY -> all outputs at reset values in the same cycle; a restart re-fetches address 0.
REQ-038 MIN_FRAME_TIMER_EN, MIN_FRAME_CYC=1000, list of 2 points -> successive frame starts are exactly 1000 cycles apart.
